// File: rtl/temporizador_regressivo.sv
// -----------------------------------------------------------------------------
// temporizador_regressivo
//
// Countdown timer. It loads a four-digit BCD preset (000.0 to 999.9 s) and
// counts it down by one decisecond per prescaler tick. When the count reaches
// 000.0, alarme is raised for ALARM_TICKS deciseconds. The timer then stays in
// DONE until the next load or reset.
//
// Parameters
//   TICK_DIV     clock cycles per decisecond tick (>= 2)
//   ALARM_TICKS  deciseconds that alarme stays high after expiry (>= 1)
//
// Ports
//   clock                         system clock; all logic runs on posedge
//   reset                         synchronous, active-high
//   carregar / iniciar / pausar   asynchronous button levels (load / start / pause)
//   PresetDs, PresetSeg0..2       preset digits in BCD (values > 9 clamp to 9)
//   CountDs, CountSeg0..2         current count digits in BCD (registered)
//   alarme                        expiry alarm (registered)
//   estado                        00 IDLE, 01 RUN, 10 PAUSE, 11 DONE (registered)
// -----------------------------------------------------------------------------
module temporizador_regressivo #(
  parameter int TICK_DIV    = 5_000_000,
  parameter int ALARM_TICKS = 30
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       carregar,
  input  logic       iniciar,
  input  logic       pausar,
  input  logic [3:0] PresetDs,
  input  logic [3:0] PresetSeg0,
  input  logic [3:0] PresetSeg1,
  input  logic [3:0] PresetSeg2,
  output logic [3:0] CountDs,
  output logic [3:0] CountSeg0,
  output logic [3:0] CountSeg1,
  output logic [3:0] CountSeg2,
  output logic       alarme,
  output logic [1:0] estado
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int AW = (ALARM_TICKS > 1) ? $clog2(ALARM_TICKS) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_TICKS - 1);

  state_t        state;
  logic [PW-1:0] presc;
  logic [AW-1:0] alarm_cnt;

  // ---------------------------------------------------------------------------
  // Button conditioning. The bits are {carregar, pausar, iniciar}. Each button
  // passes through a two-flop synchroniser and a history flop, and the rising
  // edge becomes a one-cycle pulse. Every flop resets to 1, so a button that is
  // held through reset looks as if it was already pressed and does not fire.
  // ---------------------------------------------------------------------------
  logic [2:0] btn_meta;
  logic [2:0] btn_sync;
  logic [2:0] btn_prev;
  logic [2:0] btn_pulse;

  always_ff @(posedge clock) begin
    // NOTE: all clocked state uses non-blocking assignments, so every flop
    // samples the values from before the edge, whatever the statement order.
    if (reset) begin
      btn_meta <= '1;
      btn_sync <= '1;
      btn_prev <= '1;
    end else begin
      btn_meta <= {carregar, pausar, iniciar};
      btn_sync <= btn_meta;
      btn_prev <= btn_sync;
    end
  end

  assign btn_pulse = btn_sync & ~btn_prev;

  logic pulse_load;
  logic pulse_pause;
  logic pulse_start;

  assign pulse_load  = btn_pulse[2];
  assign pulse_pause = btn_pulse[1];
  assign pulse_start = btn_pulse[0];

  // ---------------------------------------------------------------------------
  // Prescaler tick and the BCD decrement with a ripple borrow
  // ---------------------------------------------------------------------------
  logic          tick;
  logic [PW-1:0] presc_next;
  logic [3:0]    dec_ds;
  logic [3:0]    dec_s0;
  logic [3:0]    dec_s1;
  logic [3:0]    dec_s2;
  logic          borrow0;
  logic          borrow1;
  logic          borrow2;
  logic          dec_zero;
  logic          count_nz;

  function automatic logic [3:0] clamp_bcd(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  always_comb begin
    // NOTE: every signal gets a default first, so no path leaves a value
    // unassigned and no latch can be inferred.
    tick       = 1'b0;
    presc_next = presc;
    if (state == RUN || state == DONE) begin
      tick       = (presc == PRESC_MAX);
      presc_next = tick ? '0 : presc + 1'b1;
    end

    borrow0 = (CountDs == 4'd0);
    dec_ds  = borrow0 ? 4'd9 : CountDs - 4'd1;

    borrow1 = borrow0 && (CountSeg0 == 4'd0);
    dec_s0  = CountSeg0;
    if (borrow0) dec_s0 = (CountSeg0 == 4'd0) ? 4'd9 : CountSeg0 - 4'd1;

    borrow2 = borrow1 && (CountSeg1 == 4'd0);
    dec_s1  = CountSeg1;
    if (borrow1) dec_s1 = (CountSeg1 == 4'd0) ? 4'd9 : CountSeg1 - 4'd1;

    dec_s2 = CountSeg2;
    if (borrow2) dec_s2 = (CountSeg2 == 4'd0) ? 4'd9 : CountSeg2 - 4'd1;

    dec_zero = ({dec_s2, dec_s1, dec_s0, dec_ds} == 16'h0000);
    count_nz = ({CountSeg2, CountSeg1, CountSeg0, CountDs} != 16'h0000);
  end

  // ---------------------------------------------------------------------------
  // Control FSM. The count registers are the count outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      presc     <= '0;
      alarm_cnt <= '0;
      alarme    <= 1'b0;
      CountDs   <= 4'd0;
      CountSeg0 <= 4'd0;
      CountSeg1 <= 4'd0;
      CountSeg2 <= 4'd0;
    end else if (pulse_load) begin
      // A load wins over pause and start in the same cycle.
      state     <= IDLE;
      presc     <= '0;
      alarm_cnt <= '0;
      alarme    <= 1'b0;
      CountDs   <= clamp_bcd(PresetDs);
      CountSeg0 <= clamp_bcd(PresetSeg0);
      CountSeg1 <= clamp_bcd(PresetSeg1);
      CountSeg2 <= clamp_bcd(PresetSeg2);
    end else begin
      case (state)
        IDLE: begin
          if (pulse_start && count_nz) begin
            state <= RUN;
            presc <= '0;
          end
        end
        RUN: begin
          presc <= presc_next;
          if (tick && dec_zero) begin
            // Expiry overrides a pause that arrives in the same cycle.
            state     <= DONE;
            alarme    <= 1'b1;
            alarm_cnt <= '0;
            CountDs   <= 4'd0;
            CountSeg0 <= 4'd0;
            CountSeg1 <= 4'd0;
            CountSeg2 <= 4'd0;
          end else begin
            if (tick) begin
              CountDs   <= dec_ds;
              CountSeg0 <= dec_s0;
              CountSeg1 <= dec_s1;
              CountSeg2 <= dec_s2;
            end
            if (pulse_pause) state <= PAUSE;
          end
        end
        PAUSE: begin
          // The prescaler holds its partial value, so the first tick after a
          // resume comes at the remaining part of the interrupted decisecond.
          if (pulse_pause || pulse_start) state <= RUN;
        end
        DONE: begin
          presc <= presc_next;
          if (tick && alarme) begin
            if (alarm_cnt == ALARM_LAST) alarme <= 1'b0;
            else                         alarm_cnt <= alarm_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign estado = state;

endmodule

// File: tb/tb_temporizador_regressivo.sv
// -----------------------------------------------------------------------------
// Testbench for temporizador_regressivo (TICK_DIV = 4, ALARM_TICKS = 3).
//
// A reference model keeps the count as a plain integer of deciseconds and
// tracks each button as a history of sampled levels. On every clock edge it
// pushes the expected outputs into a queue. A monitor pops one entry on each
// falling edge and compares it with the DUT outputs. Directed scenarios add
// fixed-value checks, and a randomized phase follows them.
// -----------------------------------------------------------------------------
module tb_temporizador_regressivo;

  localparam int TD = 4;
  localparam int AT = 3;

  logic       clock = 1'b0;
  logic       reset;
  logic       carregar;
  logic       iniciar;
  logic       pausar;
  logic [3:0] PresetDs;
  logic [3:0] PresetSeg0;
  logic [3:0] PresetSeg1;
  logic [3:0] PresetSeg2;
  logic [3:0] CountDs;
  logic [3:0] CountSeg0;
  logic [3:0] CountSeg1;
  logic [3:0] CountSeg2;
  logic       alarme;
  logic [1:0] estado;

  temporizador_regressivo #(.TICK_DIV(TD), .ALARM_TICKS(AT)) dut (
    .clock     (clock),
    .reset     (reset),
    .carregar  (carregar),
    .iniciar   (iniciar),
    .pausar    (pausar),
    .PresetDs  (PresetDs),
    .PresetSeg0(PresetSeg0),
    .PresetSeg1(PresetSeg1),
    .PresetSeg2(PresetSeg2),
    .CountDs   (CountDs),
    .CountSeg0 (CountSeg0),
    .CountSeg1 (CountSeg1),
    .CountSeg2 (CountSeg2),
    .alarme    (alarme),
    .estado    (estado)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [15:0] count;
    logic        al;
    logic [1:0]  st;
  } exp_t;

  exp_t exp_q[$];

  int m_count;        // count in deciseconds, 0..9999
  int m_state;        // 0 IDLE, 1 RUN, 2 PAUSE, 3 DONE
  int m_phase;        // cycles elapsed in the current decisecond
  int m_alarm_left;   // alarm ticks still to go
  bit m_alarm;
  bit hc[3];          // sampled levels of carregar, [0] = last edge
  bit hp[3];
  bit hi[3];

  function automatic int clamp(input logic [3:0] d);
    return (d > 9) ? 9 : int'(d);
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic model_step();
    bit pc, pp, pi, tick;
    if (reset) begin
      m_count = 0; m_state = 0; m_phase = 0; m_alarm = 0; m_alarm_left = 0;
      for (int k = 0; k < 3; k++) begin hc[k] = 1; hp[k] = 1; hi[k] = 1; end
    end else begin
      // A press is seen at this edge when the level sampled two edges ago is
      // high and the level sampled three edges ago is low.
      pc = hc[1] && !hc[2];
      pp = hp[1] && !hp[2];
      pi = hi[1] && !hi[2];
      hc[2] = hc[1]; hc[1] = hc[0]; hc[0] = carregar;
      hp[2] = hp[1]; hp[1] = hp[0]; hp[0] = pausar;
      hi[2] = hi[1]; hi[1] = hi[0]; hi[0] = iniciar;
      if (pc) begin
        m_count = clamp(PresetSeg2) * 1000 + clamp(PresetSeg1) * 100 +
                  clamp(PresetSeg0) * 10 + clamp(PresetDs);
        m_state = 0; m_phase = 0; m_alarm = 0;
      end else begin
        tick = (m_state == 1 || m_state == 3) && (m_phase == TD - 1);
        if (m_state == 1 || m_state == 3) m_phase = (m_phase + 1) % TD;
        case (m_state)
          0: if (pi && m_count != 0) begin m_state = 1; m_phase = 0; end
          1: begin
            if (tick) m_count = m_count - 1;
            if (tick && m_count == 0) begin
              m_state = 3; m_alarm = 1; m_alarm_left = AT;
            end else if (pp) m_state = 2;
          end
          2: if (pp || pi) m_state = 1;
          default: if (tick && m_alarm) begin
            m_alarm_left--;
            if (m_alarm_left == 0) m_alarm = 0;
          end
        endcase
      end
    end
    exp_q.push_back('{count: to_bcd(m_count), al: m_alarm, st: 2'(m_state)});
  endtask

  always @(posedge clock) model_step();

  // Monitor: one comparison per cycle, away from the active edge
  always @(negedge clock) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("scoreboard", {13'd0, CountSeg2, CountSeg1, CountSeg0, CountDs, alarme, estado},
            {13'd0, e});
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic cycles(input int n);
    repeat (n) begin @(negedge clock); #1; end
  endtask

  task automatic set_preset(input logic [15:0] p);
    {PresetSeg2, PresetSeg1, PresetSeg0, PresetDs} = p;
  endtask

  task automatic press(input int which);
    if (which == 0) carregar = 1'b1;
    else if (which == 1) pausar = 1'b1;
    else iniciar = 1'b1;
    cycles(1);
    carregar = 1'b0; pausar = 1'b0; iniciar = 1'b0;
  endtask

  task automatic wait_estado(input logic [1:0] s, input int max_cycles);
    int n = 0;
    while (estado !== s && n < max_cycles) begin
      @(negedge clock); #1;
      n++;
    end
    check("wait_estado", {30'd0, estado}, {30'd0, s});
  endtask

  function automatic logic [15:0] count_now();
    return {CountSeg2, CountSeg1, CountSeg0, CountDs};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] frozen;
    reset = 1'b1; carregar = 1'b1; iniciar = 1'b0; pausar = 1'b0;
    set_preset(16'h1234);
    cycles(2);
    reset = 1'b0;
    cycles(5);
    // carregar was held across the reset release, so nothing was loaded.
    check("reset_count", {16'd0, count_now()}, 32'h0000);
    check("reset_alarme", {31'd0, alarme}, 32'd0);
    check("reset_estado", {30'd0, estado}, 32'd0);
    carregar = 1'b0;
    cycles(3);

    // Full borrow chain
    set_preset(16'h1000); press(0); cycles(4);
    check("load_1000", {16'd0, count_now()}, 32'h1000);
    press(2); wait_estado(2'b01, 10);
    cycles(3);
    check("before_tick", {16'd0, count_now()}, 32'h1000);
    cycles(1);
    check("borrow_0999", {16'd0, count_now()}, 32'h0999);

    // Expiry and alarm length
    set_preset(16'h0002); press(0); cycles(4);
    press(2); wait_estado(2'b01, 10);
    cycles(4);
    check("count_0001", {16'd0, count_now()}, 32'h0001);
    cycles(4);
    check("count_0000", {16'd0, count_now()}, 32'h0000);
    check("done_estado", {30'd0, estado}, 32'd3);
    check("alarm_on", {31'd0, alarme}, 32'd1);
    cycles(11);
    check("alarm_still_on", {31'd0, alarme}, 32'd1);
    cycles(1);
    check("alarm_off", {31'd0, alarme}, 32'd0);

    // DONE ignores iniciar; carregar reloads
    press(2); cycles(6);
    check("done_ignore_start", {30'd0, estado}, 32'd3);
    set_preset(16'h0037); press(0); cycles(4);
    check("done_reload_estado", {30'd0, estado}, 32'd0);
    check("done_reload_count", {16'd0, count_now()}, 32'h0037);

    // Pause freezes the count
    set_preset(16'h0050); press(0); cycles(4);
    press(2); wait_estado(2'b01, 10);
    press(1); wait_estado(2'b10, 10);
    frozen = count_now();
    cycles(20);
    check("pause_frozen", {16'd0, count_now()}, {16'd0, frozen});
    press(1); wait_estado(2'b01, 10);
    cycles(12);

    // carregar and iniciar in the same cycle: the load wins
    set_preset(16'h0123);
    carregar = 1'b1; iniciar = 1'b1; cycles(1);
    carregar = 1'b0; iniciar = 1'b0; cycles(6);
    check("load_beats_start", {30'd0, estado}, 32'd0);
    check("load_beats_start_cnt", {16'd0, count_now()}, 32'h0123);

    // Zero preset cannot start
    set_preset(16'h0000); press(0); cycles(4);
    press(2); cycles(6);
    check("zero_no_start", {30'd0, estado}, 32'd0);

    // Digit clamp
    set_preset(16'h0A00); press(0); cycles(4);
    check("clamp_0900", {16'd0, count_now()}, 32'h0900);

    // Reset in the middle of RUN
    press(2); cycles(9);
    reset = 1'b1; cycles(1); reset = 1'b0; cycles(1);
    check("midrun_reset", {13'd0, count_now(), alarme, estado}, 32'd0);

    // Randomized phase
    for (int n = 0; n < 3000; n++) begin
      @(negedge clock);
      reset = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 9) == 0) carregar = ~carregar;
      if ($urandom_range(0, 11) == 0) pausar = ~pausar;
      if ($urandom_range(0, 5) == 0) iniciar = ~iniciar;
      if ($urandom_range(0, 19) == 0) begin
        PresetDs   = 4'($urandom_range(0, 3));
        PresetSeg0 = 4'($urandom_range(0, 2));
        PresetSeg1 = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
        PresetSeg2 = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
      end
    end
    reset = 1'b0; carregar = 1'b0; pausar = 1'b0; iniciar = 1'b0;
    cycles(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
